// File: rtl/mem_pkg.sv
// Shared encodings for the memory access stage: func3 access codes,
// fault cause codes and the FSM state type.
package mem_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    localparam logic [1:0] CAUSE_NONE       = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGNED = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL    = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT    = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        RESP = 2'b10
    } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store data replication and write mask,
// load byte/half extraction with sign or zero extension.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  i_st_size,
    input  logic [1:0]  i_st_off,
    input  logic [31:0] i_st_wdata,
    output logic [31:0] o_st_wdata,
    output logic [3:0]  o_st_wmask,
    input  logic [2:0]  i_ld_func3,
    input  logic [1:0]  i_ld_off,
    input  logic [31:0] i_ld_rdata,
    output logic [31:0] o_ld_data
);

    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;

    // Each lane carries the byte or half replicated so any offset finds its data.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign o_st_wdata[8*gi +: 8] = (i_st_size == 2'b00) ? i_st_wdata[7:0] :
                                       (i_st_size == 2'b01) ? i_st_wdata[8*(gi%2) +: 8] :
                                                              i_st_wdata[8*gi +: 8];
    end

    always_comb begin
        o_st_wmask = 4'b1111;
        case (i_st_size)
            2'b00:   o_st_wmask = 4'b0001 << i_st_off;
            2'b01:   o_st_wmask = 4'b0011 << i_st_off;
            default: o_st_wmask = 4'b1111;
        endcase
    end

    always_comb begin
        w_ld_byte = i_ld_rdata[7:0];
        case (i_ld_off)
            2'd0:    w_ld_byte = i_ld_rdata[7:0];
            2'd1:    w_ld_byte = i_ld_rdata[15:8];
            2'd2:    w_ld_byte = i_ld_rdata[23:16];
            default: w_ld_byte = i_ld_rdata[31:24];
        endcase
        w_ld_half = i_ld_off[1] ? i_ld_rdata[31:16] : i_ld_rdata[15:0];
    end

    always_comb begin
        o_ld_data = i_ld_rdata;
        case (i_ld_func3)
            LB:      o_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
            LH:      o_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
            LBU:     o_ld_data = {24'h0, w_ld_byte};
            LHU:     o_ld_data = {16'h0, w_ld_half};
            default: o_ld_data = i_ld_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: decodes a load/store from execute, runs the req/ack handshake
// with data memory, and reports a one-cycle done with data or fault cause.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1023,
    parameter int unsigned CNT_W   = 10
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  func3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata_out,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_wmask,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);

    localparam bit             TO_EN   = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    state_t            r_state;
    logic [2:0]        r_func3;
    logic [1:0]        r_off;
    logic              r_is_load;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_done;
    logic [31:0]       r_rdata;
    logic              r_fault;
    logic [1:0]        r_cause;
    logic              r_req;
    logic              r_we;
    logic [31:0]       r_daddr;
    logic [3:0]        r_wmask;
    logic [31:0]       r_wdata;

    logic              w_start;
    logic              w_illegal;
    logic              w_misaligned;
    logic [1:0]        w_cause;
    logic [31:0]       w_st_wdata;
    logic [3:0]        w_st_wmask;
    logic [31:0]       w_ld_data;

    mem_lane_align u_align (
        .i_st_size  (func3[1:0]),
        .i_st_off   (addr[1:0]),
        .i_st_wdata (wdata_in),
        .o_st_wdata (w_st_wdata),
        .o_st_wmask (w_st_wmask),
        .i_ld_func3 (r_func3),
        .i_ld_off   (r_off),
        .i_ld_rdata (dmem_rdata),
        .o_ld_data  (w_ld_data)
    );

    assign w_start = valid_in & (MemRead | MemWrite) & (r_state == IDLE);

    assign w_illegal = (MemRead & MemWrite)
                     | (MemRead & ((func3 == 3'b011) | (func3 == 3'b110) | (func3 == 3'b111)))
                     | (MemWrite & (func3 > 3'b010));

    assign w_misaligned = ((func3[1:0] == 2'b01) & addr[0])
                        | ((func3[1:0] == 2'b10) & (addr[1:0] != 2'b00));

    // Illegal outranks misaligned: a bad func3 makes the width meaningless.
    assign w_cause = w_illegal    ? CAUSE_ILLEGAL :
                     w_misaligned ? CAUSE_MISALIGNED : CAUSE_NONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_func3   <= '0;
            r_off     <= '0;
            r_is_load <= 1'b0;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_rdata   <= '0;
            r_fault   <= 1'b0;
            r_cause   <= CAUSE_NONE;
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_daddr   <= '0;
            r_wmask   <= '0;
            r_wdata   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_func3   <= func3;
                        r_off     <= addr[1:0];
                        r_is_load <= MemRead;
                        r_cnt     <= '0;
                        if (w_cause != CAUSE_NONE) begin
                            r_state <= RESP;
                            r_done  <= 1'b1;
                            r_fault <= 1'b1;
                            r_cause <= w_cause;
                            r_rdata <= '0;
                        end else begin
                            r_state <= REQ;
                            r_req   <= 1'b1;
                            r_we    <= MemWrite;
                            r_daddr <= {addr[31:2], 2'b00};
                            r_wmask <= MemWrite ? w_st_wmask : 4'b0000;
                            r_wdata <= MemWrite ? w_st_wdata : 32'h0;
                        end
                    end
                end
                REQ: begin
                    if (dmem_ack || (TO_EN && (r_cnt == TO_LAST))) begin
                        r_state <= RESP;
                        r_done  <= 1'b1;
                        r_req   <= 1'b0;
                        r_we    <= 1'b0;
                        r_daddr <= '0;
                        r_wmask <= '0;
                        r_wdata <= '0;
                        if (dmem_ack) begin
                            r_rdata <= r_is_load ? w_ld_data : 32'h0;
                        end else begin
                            r_rdata <= '0;
                            r_fault <= 1'b1;
                            r_cause <= CAUSE_TIMEOUT;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_fault <= 1'b0;
                    r_cause <= CAUSE_NONE;
                    r_rdata <= '0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy        = (r_state != IDLE);
    assign done        = r_done;
    assign rdata_out   = r_rdata;
    assign fault       = r_fault;
    assign fault_cause = r_cause;
    assign dmem_req    = r_req;
    assign dmem_we     = r_we;
    assign dmem_addr   = r_daddr;
    assign dmem_wmask  = r_wmask;
    assign dmem_wdata  = r_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, faults, timeout,
// mid-access reset and back-to-back starts, TIMEOUT reduced to 8.
module tb_mem_access_unit;

    localparam logic [2:0] F_LB = 3'b000, F_LH = 3'b001, F_LW = 3'b010;
    localparam logic [2:0] F_LBU = 3'b100, F_LHU = 3'b101;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_in = 1'b0, MemRead = 1'b0, MemWrite = 1'b0;
    logic [2:0]  func3 = '0;
    logic [31:0] addr = '0, wdata_in = '0;
    logic        busy, done, fault, dmem_req, dmem_we;
    logic [31:0] rdata_out, dmem_addr, dmem_wdata;
    logic [1:0]  fault_cause;
    logic [3:0]  dmem_wmask;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .MemRead(MemRead), .MemWrite(MemWrite),
        .func3(func3), .addr(addr), .wdata_in(wdata_in), .busy(busy), .done(done),
        .rdata_out(rdata_out), .fault(fault), .fault_cause(fault_cause),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
    );

    // Present one start for a single cycle, returning at the following negedge.
    task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        valid_in = 1'b1; MemRead = rd; MemWrite = wr; func3 = f3; addr = a; wdata_in = wd;
        @(negedge clk);
        valid_in = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({busy, done, fault, fault_cause, dmem_req, dmem_we} !== 7'b0 ||
            rdata_out !== 32'h0 || dmem_addr !== 32'h0 || dmem_wmask !== 4'h0 || dmem_wdata !== 32'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got busy=%b done=%b req=%b addr=%h want all zero", busy, done, dmem_req, dmem_addr);
        end
        rst = 1'b0;
        @(negedge clk);
        $display("reset: outputs checked");
    endtask

    task automatic test_idle_ignores;
        // valid without an op, and a stray ack, must not start anything
        valid_in = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'h5555_5555;
        @(negedge clk);
        valid_in = 1'b0; dmem_ack = 1'b0;
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || dmem_req !== 1'b0) begin
            n_err++;
            $display("FAIL idle_ignore: got busy=%b done=%b req=%b want 0 0 0", busy, done, dmem_req);
        end
        $display("idle: no-op valid and stray ack ignored");
    endtask

    task automatic test_loads;
        logic [2:0]  t_f3   [7] = '{F_LW, F_LB, F_LBU, F_LH, F_LHU, F_LB, F_LH};
        logic [31:0] t_addr [7] = '{32'h100, 32'h103, 32'h103, 32'h102, 32'h102, 32'h101, 32'h200};
        logic [31:0] t_rd   [7] = '{32'hDEADBEEF, 32'h80FFFFFF, 32'h80FFFFFF, 32'h80FFFFFF,
                                    32'h80FFFFFF, 32'h12345678, 32'h0000F00D};
        logic [31:0] t_exp  [7] = '{32'hDEADBEEF, 32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF,
                                    32'h000080FF, 32'h00000056, 32'hFFFFF00D};
        logic [31:0] t_da   [7] = '{32'h100, 32'h100, 32'h100, 32'h100, 32'h100, 32'h100, 32'h200};
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b0, t_f3[i], t_addr[i], 32'hFFFF_FFFF);
            n_vec++;
            if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_wmask !== 4'b0000 ||
                dmem_addr !== t_da[i] || busy !== 1'b1 || done !== 1'b0) begin
                n_err++;
                $display("FAIL load%0d_req: got req=%b we=%b mask=%b addr=%h busy=%b done=%b want 1 0 0000 %h 1 0",
                         i, dmem_req, dmem_we, dmem_wmask, dmem_addr, busy, done, t_da[i]);
            end
            dmem_ack = 1'b1; dmem_rdata = t_rd[i];
            @(negedge clk);
            dmem_ack = 1'b0; dmem_rdata = 32'h0;
            n_vec++;
            if (done !== 1'b1 || fault !== 1'b0 || fault_cause !== 2'b00 || rdata_out !== t_exp[i]) begin
                n_err++;
                $display("FAIL load%0d_data: got done=%b fault=%b rdata_out=%h want 1 0 %h",
                         i, done, fault, rdata_out, t_exp[i]);
            end
            @(negedge clk);
            n_vec++;
            if (done !== 1'b0 || busy !== 1'b0 || rdata_out !== 32'h0) begin
                n_err++;
                $display("FAIL load%0d_end: got done=%b busy=%b rdata_out=%h want 0 0 0", i, done, busy, rdata_out);
            end
            $display("load f3=%b addr=%h mem=%h -> rdata_out=%h", t_f3[i], t_addr[i], t_rd[i], t_exp[i]);
        end
    endtask

    task automatic test_stores;
        logic [2:0]  t_f3   [5] = '{3'b001, 3'b000, 3'b000, 3'b010, 3'b001};
        logic [31:0] t_addr [5] = '{32'h202, 32'h201, 32'h207, 32'h208, 32'h300};
        logic [31:0] t_wd   [5] = '{32'h1234ABCD, 32'h000000EF, 32'h9999995A, 32'h11223344, 32'hCAFE8765};
        logic [31:0] t_da   [5] = '{32'h200, 32'h200, 32'h204, 32'h208, 32'h300};
        logic [31:0] t_ew   [5] = '{32'hABCDABCD, 32'hEFEFEFEF, 32'h5A5A5A5A, 32'h11223344, 32'h87658765};
        logic [3:0]  t_em   [5] = '{4'b1100, 4'b0010, 4'b1000, 4'b1111, 4'b0011};
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, t_f3[i], t_addr[i], t_wd[i]);
            for (int c = 0; c < 2; c++) begin
                n_vec++;
                if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== t_da[i] ||
                    dmem_wdata !== t_ew[i] || dmem_wmask !== t_em[i] || done !== 1'b0) begin
                    n_err++;
                    $display("FAIL store%0d_req_c%0d: got req=%b we=%b addr=%h wdata=%h mask=%b want 1 1 %h %h %b",
                             i, c, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wmask, t_da[i], t_ew[i], t_em[i]);
                end
                if (c == 1) begin
                    dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
                end
                @(negedge clk);
            end
            dmem_ack = 1'b0; dmem_rdata = 32'h0;
            n_vec++;
            if (done !== 1'b1 || fault !== 1'b0 || rdata_out !== 32'h0 || dmem_req !== 1'b0) begin
                n_err++;
                $display("FAIL store%0d_done: got done=%b fault=%b rdata_out=%h req=%b want 1 0 0 0",
                         i, done, fault, rdata_out, dmem_req);
            end
            @(negedge clk);
            $display("store f3=%b addr=%h data=%h -> wdata=%h mask=%b", t_f3[i], t_addr[i], t_wd[i], t_ew[i], t_em[i]);
        end
    endtask

    task automatic test_faults;
        logic        t_rd   [13] = '{0, 0, 1, 1, 0, 1, 1, 1, 1, 0, 0, 1, 1};
        logic        t_wr   [13] = '{1, 1, 0, 0, 1, 0, 0, 0, 0, 1, 1, 1, 0};
        logic [2:0]  t_f3   [13] = '{3'b010, 3'b010, 3'b001, 3'b101, 3'b001, 3'b010, 3'b011,
                                     3'b110, 3'b111, 3'b011, 3'b100, 3'b010, 3'b011};
        logic [31:0] t_addr [13] = '{32'h101, 32'h102, 32'h101, 32'h103, 32'h105, 32'h103, 32'h0,
                                     32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h101};
        logic [1:0]  t_c    [13] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10,
                                     2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
        for (int i = 0; i < 13; i++) begin
            dmem_rdata = 32'hA5A5_A5A5;
            drive(t_rd[i], t_wr[i], t_f3[i], t_addr[i], 32'h1234_5678);
            n_vec++;
            if (done !== 1'b1 || fault !== 1'b1 || fault_cause !== t_c[i] ||
                dmem_req !== 1'b0 || rdata_out !== 32'h0) begin
                n_err++;
                $display("FAIL fault%0d: got done=%b fault=%b cause=%b req=%b rdata_out=%h want 1 1 %b 0 0",
                         i, done, fault, fault_cause, dmem_req, rdata_out, t_c[i]);
            end
            @(negedge clk);
            n_vec++;
            if (done !== 1'b0 || fault !== 1'b0 || busy !== 1'b0 || dmem_req !== 1'b0) begin
                n_err++;
                $display("FAIL fault%0d_end: got done=%b fault=%b busy=%b req=%b want 0 0 0 0",
                         i, done, fault, busy, dmem_req);
            end
            $display("fault rd=%b wr=%b f3=%b addr=%h -> cause=%b", t_rd[i], t_wr[i], t_f3[i], t_addr[i], t_c[i]);
        end
    endtask

    task automatic test_timeout;
        drive(1'b0, 1'b1, 3'b010, 32'h300, 32'hCAFEF00D);
        for (int c = 0; c < 8; c++) begin
            n_vec++;
            if (dmem_req !== 1'b1 || dmem_addr !== 32'h300 || dmem_wdata !== 32'hCAFEF00D ||
                dmem_wmask !== 4'b1111 || dmem_we !== 1'b1 || done !== 1'b0) begin
                n_err++;
                $display("FAIL timeout_hold_c%0d: got req=%b addr=%h wdata=%h mask=%b done=%b want 1 300 cafef00d 1111 0",
                         c, dmem_req, dmem_addr, dmem_wdata, dmem_wmask, done);
            end
            @(negedge clk);
        end
        n_vec++;
        if (done !== 1'b1 || fault !== 1'b1 || fault_cause !== 2'b11 || dmem_req !== 1'b0 || rdata_out !== 32'h0) begin
            n_err++;
            $display("FAIL timeout_done: got done=%b fault=%b cause=%b req=%b want 1 1 11 0",
                     done, fault, fault_cause, dmem_req);
        end
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_end: got busy=%b done=%b want 0 0", busy, done);
        end
        $display("timeout sw addr=00000300 -> cause=11 after 8 req cycles");
    endtask

    task automatic test_reset_mid_access;
        drive(1'b1, 1'b0, F_LW, 32'h400, 32'h0);
        n_vec++;
        if (dmem_req !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_req: got req=%b want 1", dmem_req);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_vec++;
        if (dmem_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_drop: got req=%b busy=%b done=%b want 0 0 0", dmem_req, busy, done);
        end
        dmem_ack = 1'b1; dmem_rdata = 32'h7777_7777;
        @(negedge clk);
        dmem_ack = 1'b0;
        n_vec++;
        if (done !== 1'b0 || busy !== 1'b0 || rdata_out !== 32'h0) begin
            n_err++;
            $display("FAIL rstmid_late_ack: got done=%b busy=%b rdata_out=%h want 0 0 0", done, busy, rdata_out);
        end
        drive(1'b1, 1'b0, F_LW, 32'h104, 32'h0);
        n_vec++;
        if (dmem_req !== 1'b1 || dmem_addr !== 32'h104) begin
            n_err++;
            $display("FAIL rstmid_next_req: got req=%b addr=%h want 1 104", dmem_req, dmem_addr);
        end
        dmem_ack = 1'b1; dmem_rdata = 32'h0BADF00D;
        @(negedge clk);
        dmem_ack = 1'b0;
        n_vec++;
        if (done !== 1'b1 || fault !== 1'b0 || rdata_out !== 32'h0BADF00D) begin
            n_err++;
            $display("FAIL rstmid_next_done: got done=%b fault=%b rdata_out=%h want 1 0 0badf00d", done, fault, rdata_out);
        end
        @(negedge clk);
        $display("reset mid-access: req dropped, late ack ignored, next lw returned 0badf00d");
    endtask

    task automatic test_back_to_back;
        valid_in = 1'b1; MemRead = 1'b1; func3 = F_LW; addr = 32'h500;
        @(negedge clk);
        n_vec++;
        if (dmem_req !== 1'b1 || dmem_addr !== 32'h500) begin
            n_err++;
            $display("FAIL b2b_req1: got req=%b addr=%h want 1 500", dmem_req, dmem_addr);
        end
        dmem_ack = 1'b1; dmem_rdata = 32'h1111_1111;
        @(negedge clk);
        dmem_ack = 1'b0;
        n_vec++;
        if (done !== 1'b1 || rdata_out !== 32'h1111_1111) begin
            n_err++;
            $display("FAIL b2b_done1: got done=%b rdata_out=%h want 1 11111111", done, rdata_out);
        end
        addr = 32'h504;
        @(negedge clk);
        n_vec++;
        if (dmem_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_idle: got req=%b busy=%b done=%b want 0 0 0", dmem_req, busy, done);
        end
        @(negedge clk);
        valid_in = 1'b0; MemRead = 1'b0;
        n_vec++;
        if (dmem_req !== 1'b1 || dmem_addr !== 32'h504) begin
            n_err++;
            $display("FAIL b2b_req2: got req=%b addr=%h want 1 504", dmem_req, dmem_addr);
        end
        dmem_ack = 1'b1; dmem_rdata = 32'h2222_2222;
        @(negedge clk);
        dmem_ack = 1'b0;
        n_vec++;
        if (done !== 1'b1 || rdata_out !== 32'h2222_2222) begin
            n_err++;
            $display("FAIL b2b_done2: got done=%b rdata_out=%h want 1 22222222", done, rdata_out);
        end
        @(negedge clk);
        $display("back-to-back lw 500/504 -> 11111111, 22222222");
    endtask

    initial begin
        test_reset;
        test_idle_ignores;
        test_loads;
        test_stores;
        test_faults;
        test_timeout;
        test_reset_mid_access;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
